// File: rtl/line_window_gen_if.sv
// Padded-pixel stream in, KxK window stream out, between the row-padding stage and the convolution stages.
// The master side is the pipeline/bench; the slave side is line_window_gen.
interface line_window_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 640,
  parameter int ROWS       = 512,
  parameter int K          = 5
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(WIDTH);

  logic                       frame_en;
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic [K*K*DATA_WIDTH-1:0]  win_data;
  logic                       win_valid;
  logic [RW-1:0]              win_row;
  logic [CW-1:0]              win_col;
  logic                       frame_done;
  logic                       frame_err;

  modport master (
    output frame_en, in_valid, in_data,
    input  win_data, win_valid, win_row, win_col, frame_done, frame_err
  );

  modport slave (
    input  frame_en, in_valid, in_data,
    output win_data, win_valid, win_row, win_col, frame_done, frame_err
  );
endinterface

// File: rtl/line_window_gen.sv
// KxK sliding-window generator over K-1 cascaded line buffers; window valid 2 cycles after the completing pixel.
// No backpressure: every accepted pixel moves the pipeline one step, idle cycles simply hold it.
module line_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 640,
  parameter int ROWS       = 512,
  parameter int K          = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  line_window_gen_if.slave   bus
);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(WIDTH);
  localparam int NB   = K - 1;
  localparam int HALF = (K - 1) / 2;

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [CW-1:0] COL_HALF  = CW'(HALF);
  localparam logic [RW-1:0] ROW_HALF  = RW'(HALF);

  logic                  accept;
  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic                  row_wrapped;

  // Index 0 holds the oldest line, NB-1 the line just before the current one.
  logic [DATA_WIDTH-1:0] line_buf [NB][WIDTH];

  logic [DATA_WIDTH-1:0] col_vec [K];
  logic                  s1_vld;
  logic                  s1_complete;
  logic                  s1_last;
  logic [RW-1:0]         s1_row;
  logic [CW-1:0]         s1_col;

  logic [DATA_WIDTH-1:0] win [K][K];
  logic                  win_valid;
  logic                  frame_done;
  logic                  frame_err;
  logic [RW-1:0]         win_row;
  logic [CW-1:0]         win_col;

  assign accept = bus.frame_en & bus.in_valid;

  // Read-before-write cascade: each line moves one buffer older at the same column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NB - 1; j++) begin
        line_buf[j][col_cnt] <= line_buf[j+1][col_cnt];
      end
      line_buf[NB-1][col_cnt] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      row_wrapped <= 1'b0;
      s1_vld      <= 1'b0;
      s1_complete <= 1'b0;
      s1_last     <= 1'b0;
      s1_row      <= '0;
      s1_col      <= '0;
      frame_err   <= 1'b0;
      for (int r = 0; r < K; r++) col_vec[r] <= '0;
    end else if (!bus.frame_en) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      row_wrapped <= 1'b0;
      s1_vld      <= 1'b0;
      s1_complete <= 1'b0;
      s1_last     <= 1'b0;
      if (col_cnt != '0) frame_err <= 1'b1;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        for (int j = 0; j < NB; j++) col_vec[j] <= line_buf[j][col_cnt];
        col_vec[K-1] <= bus.in_data;
        s1_complete  <= (row_cnt >= ROW_FIRST) && (col_cnt >= COL_FIRST);
        s1_last      <= (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
        s1_row       <= row_cnt - ROW_HALF;
        s1_col       <= col_cnt - COL_HALF;
        // A pixel arriving after the row counter wrapped means the frame ran long.
        if (row_wrapped) frame_err <= 1'b1;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          if (row_cnt == ROW_LAST) begin
            row_cnt     <= '0;
            row_wrapped <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (!bus.frame_en) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else begin
      win_valid  <= s1_vld & s1_complete;
      frame_done <= s1_vld & s1_complete & s1_last;
      if (s1_vld) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= col_vec[r];
        end
      end
      // Centre coordinates are only meaningful for complete windows.
      if (s1_vld && s1_complete) begin
        win_row <= s1_row;
        win_col <= s1_col;
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign bus.win_data[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
    end
  end

  assign bus.win_valid  = win_valid;
  assign bus.win_row    = win_row;
  assign bus.win_col    = win_col;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen with K=3, WIDTH=8, ROWS=6 and pixel value row*16+col.
module tb_line_window_gen;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int R  = 6;
  localparam int K  = 3;
  localparam int RW = $clog2(R);
  localparam int CW = $clog2(W);

  typedef struct packed {
    logic [K*K*DW-1:0] data;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              done;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   win_cnt = 0;
  int   done_cnt = 0;
  logic [DW-1:0] cap_tap00;
  exp_t q[$];
  exp_t mon_e;

  line_window_gen_if #(.DATA_WIDTH(DW), .WIDTH(W), .ROWS(R), .K(K)) bus();

  line_window_gen #(.DATA_WIDTH(DW), .WIDTH(W), .ROWS(R), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every window the DUT emits must match the head of the expectation queue.
  always @(negedge clk) begin
    n_cmp++;
    if (bus.frame_done !== 1'b0 && bus.win_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL done_without_valid frame_done=%b win_valid=%b", bus.frame_done, bus.win_valid);
    end
    if (bus.win_valid === 1'b1) begin
      win_cnt++;
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.win_row == 2 && bus.win_col == 1) cap_tap00 = bus.win_data[DW-1:0];
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_window row=%0d col=%0d data=%h", bus.win_row, bus.win_col, bus.win_data);
      end else begin
        mon_e = q.pop_front();
        if (bus.win_data !== mon_e.data) begin
          n_bad++;
          $display("FAIL win_data got=%h exp=%h", bus.win_data, mon_e.data);
        end
        n_cmp++;
        if (bus.win_row !== mon_e.row) begin
          n_bad++;
          $display("FAIL win_row got=%0d exp=%0d", bus.win_row, mon_e.row);
        end
        n_cmp++;
        if (bus.win_col !== mon_e.col) begin
          n_bad++;
          $display("FAIL win_col got=%0d exp=%0d", bus.win_col, mon_e.col);
        end
        n_cmp++;
        if (bus.frame_done !== mon_e.done) begin
          n_bad++;
          $display("FAIL frame_done got=%b exp=%b", bus.frame_done, mon_e.done);
        end
        n_cmp++;
        if (cyc !== mon_e.cyc) begin
          n_bad++;
          $display("FAIL latency window_cycle got=%0d exp=%0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic send_pixel(input int r, input int c, input bit gap);
    exp_t e;
    @(negedge clk);
    bus.frame_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(r * 16 + c);
    if (r >= K - 1 && r < R && c >= K - 1) begin
      e = '0;
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++)
          e.data[(rr*K+cc)*DW +: DW] = DW'((r - (K - 1) + rr) * 16 + (c - (K - 1) + cc));
      e.row  = RW'(r - (K - 1) / 2);
      e.col  = CW'(c - (K - 1) / 2);
      e.done = (r == R - 1) && (c == W - 1);
      e.cyc  = cyc + 2;
      q.push_back(e);
    end
    if (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_rows(input int r0, input int r1, input bit gap);
    for (int r = r0; r < r1; r++)
      for (int c = 0; c < W; c++) send_pixel(r, c, gap);
  endtask

  task automatic end_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.frame_en = 1'b1;
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.frame_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #3;
    n_cmp++; if (bus.win_data !== '0) begin n_bad++; $display("FAIL reset_win_data got=%h exp=0", bus.win_data); end
    n_cmp++; if (bus.win_valid !== 1'b0) begin n_bad++; $display("FAIL reset_win_valid got=%b exp=0", bus.win_valid); end
    n_cmp++; if (bus.win_row !== '0) begin n_bad++; $display("FAIL reset_win_row got=%0d exp=0", bus.win_row); end
    n_cmp++; if (bus.win_col !== '0) begin n_bad++; $display("FAIL reset_win_col got=%0d exp=0", bus.win_col); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_frame_counts(input string name, input int exp_win, input int exp_done);
    n_cmp++;
    if (win_cnt !== exp_win) begin n_bad++; $display("FAIL %s window_count got=%0d exp=%0d", name, win_cnt, exp_win); end
    n_cmp++;
    if (done_cnt !== exp_done) begin n_bad++; $display("FAIL %s frame_done_count got=%0d exp=%0d", name, done_cnt, exp_done); end
    n_cmp++;
    if (q.size() !== 0) begin n_bad++; $display("FAIL %s missing_windows got=%0d exp=0", name, q.size()); end
  endtask

  task automatic test_continuous();
    win_cnt = 0; done_cnt = 0;
    send_rows(0, R, 1'b0);
    end_frame();
    check_frame_counts("continuous", 24, 1);
  endtask

  task automatic test_gapped();
    win_cnt = 0; done_cnt = 0;
    send_rows(0, R, 1'b1);
    end_frame();
    check_frame_counts("gapped", 24, 1);
  endtask

  task automatic test_line_boundary();
    win_cnt = 0; done_cnt = 0;
    cap_tap00 = 16'hFFFF;
    send_rows(0, R, 1'b0);
    end_frame();
    n_cmp++;
    if (cap_tap00 !== 16'h0010) begin n_bad++; $display("FAIL boundary_tap00 got=%h exp=0010", cap_tap00); end
    check_frame_counts("boundary", 24, 1);
  endtask

  task automatic test_frame_drop();
    win_cnt = 0; done_cnt = 0;
    send_rows(0, 3, 1'b0);
    for (int c = 0; c <= 4; c++) send_pixel(3, c, 1'b0);
    void'(q.pop_back());
    @(negedge clk);
    bus.frame_en = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.win_valid !== 1'b0) begin n_bad++; $display("FAIL drop_win_valid got=%b exp=0", bus.win_valid); end
    n_cmp++;
    if (bus.frame_err !== 1'b1) begin n_bad++; $display("FAIL drop_frame_err got=%b exp=1", bus.frame_err); end
    check_frame_counts("drop", 8, 0);
    win_cnt = 0; done_cnt = 0;
    send_rows(0, R, 1'b0);
    end_frame();
    check_frame_counts("after_drop", 24, 1);
  endtask

  task automatic test_row_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL wrap_reset_clears_err got=%b exp=0", bus.frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    win_cnt = 0; done_cnt = 0;
    send_rows(0, R, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    n_cmp++;
    if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL wrap_err_before_line7 got=%b exp=0", bus.frame_err); end
    send_pixel(R, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.frame_err !== 1'b1) begin n_bad++; $display("FAIL wrap_err_after_line7 got=%b exp=1", bus.frame_err); end
    check_frame_counts("wrap", 24, 1);
    bus.frame_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL wrap_err_cleared got=%b exp=0", bus.frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    send_rows(0, 3, 1'b0);
    for (int c = 0; c <= 3; c++) send_pixel(3, c, 1'b0);
    #7;
    n_cmp++;
    if (bus.win_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid got=%b exp=1", bus.win_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.win_valid !== 1'b0) begin n_bad++; $display("FAIL areset_win_valid got=%b exp=0", bus.win_valid); end
    n_cmp++;
    if (bus.win_data !== '0) begin n_bad++; $display("FAIL areset_win_data got=%h exp=0", bus.win_data); end
    n_cmp++;
    if (bus.win_row !== '0 || bus.win_col !== '0) begin
      n_bad++; $display("FAIL areset_centre got=%0d,%0d exp=0,0", bus.win_row, bus.win_col);
    end
    q.delete();
    bus.frame_en = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    win_cnt = 0; done_cnt = 0;
    send_rows(0, R, 1'b0);
    end_frame();
    check_frame_counts("after_areset", 24, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_line_boundary();
    test_frame_drop();
    test_row_wrap();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
